xfer_strobe_seq: RTL and testbench

- Initiator side of the latch/output-enable register-transfer protocol: sequences one bus transfer from a source register onto the shared 12-bit bus and into a destination register.
- Drives one-hot output-enables to source latches and one-hot latch strobes to destination latches.
- Timing guarantees that edge-detecting destination latches capture exactly once per transfer.
- Sits between the instruction-cycle control logic and the register/latch bank.

---
 rtl/xfer_strobe_seq.sv | 142 ++++++++++++++
 tb/tb_xfer_strobe_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/xfer_strobe_seq.sv
// xfer_strobe_seq
// Initiator side of the latch/output-enable register-transfer protocol. One
// accepted request drives a source onto the shared bus (oe), waits SETTLE
// cycles, then pulses the destination latch strobe for HOLD cycles. It keeps
// oe asserted for one more cycle of hold time and then returns to idle.
// Every strobe is preceded by at least SETTLE+2 low cycles, so an
// edge-detecting latch captures exactly once per transfer.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_req            transfer request (level, sampled only when idle)
//   i_src, i_src_en  source index / drive enable (0 = bus reads 0)
//   i_dst, i_dst_en  destination index / strobe enable (0 = no strobe)
//   o_ack            one-cycle pulse on accept
//   o_busy           high from accept until back in idle
//   o_done           one-cycle pulse on completion
//   o_err            one-cycle pulse on rejection (index out of range)
//   o_oe             one-hot source output-enables
//   o_latch          one-hot destination latch strobes
module xfer_strobe_seq #(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned NDST   = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned HOLD   = 1,
    localparam int unsigned SW = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int unsigned DW = (NDST > 1) ? $clog2(NDST) : 1
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req,
    input  logic [SW-1:0]   i_src,
    input  logic [DW-1:0]   i_dst,
    input  logic            i_src_en,
    input  logic            i_dst_en,
    output logic            o_ack,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic [NSRC-1:0] o_oe,
    output logic [NDST-1:0] o_latch
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_STROBE,
        ST_RELEASE
    } state_t;

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [DW-1:0]   r_dst;
    logic            r_dst_en;
    logic            r_ack;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [NSRC-1:0] r_oe;
    logic [NDST-1:0] r_latch;

    logic            w_bad;
    logic [NSRC-1:0] w_oe_hot;
    logic [NDST-1:0] w_latch_hot;

    // An index is only checked when its enable is set; a disabled side may
    // carry any value.
    always_comb begin
        w_bad = (i_src_en && (32'(i_src) >= NSRC)) ||
                (i_dst_en && (32'(i_dst) >= NDST));
        w_oe_hot    = NSRC'(1) << i_src;
        w_latch_hot = NDST'(1) << r_dst;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dst    <= '0;
            r_dst_en <= 1'b0;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_oe     <= '0;
            r_latch  <= '0;
        end else begin
            r_ack  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        if (w_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ack    <= 1'b1;
                            r_busy   <= 1'b1;
                            r_oe     <= i_src_en ? w_oe_hot : '0;
                            r_dst    <= i_dst;
                            r_dst_en <= i_dst_en;
                            r_cnt    <= 4'(SETTLE - 1);
                            r_state  <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_latch <= r_dst_en ? w_latch_hot : '0;
                        r_cnt   <= 4'(HOLD - 1);
                        r_state <= ST_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_latch <= '0;
                        r_state <= ST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RELEASE: begin
                    // oe was held one extra cycle past the latch falling edge.
                    r_oe    <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ack   = r_ack;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_oe    = r_oe;
    assign o_latch = r_latch;

endmodule

// File: tb/tb_xfer_strobe_seq.sv
// Directed bench for xfer_strobe_seq. Three instances share the inputs:
//   sel 0: defaults, sel 1: SETTLE=3/HOLD=2, sel 2: NSRC=3.
// Each step drives inputs, clocks once and compares the packed outputs
// {ack, busy, done, err, oe[3:0], latch[3:0]} of the selected instance.
module tb_xfer_strobe_seq;

    logic       clk;
    logic       reset;
    logic       req;
    logic [1:0] src;
    logic [1:0] dst;
    logic       src_en;
    logic       dst_en;

    logic       ack0, busy0, done0, err0;
    logic [3:0] oe0, latch0;
    logic       ack1, busy1, done1, err1;
    logic [3:0] oe1, latch1;
    logic       ack2, busy2, done2, err2;
    logic [2:0] oe2;
    logic [3:0] latch2;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    xfer_strobe_seq u_dut0 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_src(src), .i_dst(dst),
        .i_src_en(src_en), .i_dst_en(dst_en), .o_ack(ack0), .o_busy(busy0),
        .o_done(done0), .o_err(err0), .o_oe(oe0), .o_latch(latch0)
    );

    xfer_strobe_seq #(.SETTLE(3), .HOLD(2)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_src(src), .i_dst(dst),
        .i_src_en(src_en), .i_dst_en(dst_en), .o_ack(ack1), .o_busy(busy1),
        .o_done(done1), .o_err(err1), .o_oe(oe1), .o_latch(latch1)
    );

    xfer_strobe_seq #(.NSRC(3)) u_dut2 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_src(src), .i_dst(dst),
        .i_src_en(src_en), .i_dst_en(dst_en), .o_ack(ack2), .o_busy(busy2),
        .o_done(done2), .o_err(err2), .o_oe(oe2), .o_latch(latch2)
    );

    typedef struct {
        int         sel;
        bit         rst;
        bit         rq;
        bit [1:0]   s;
        bit [1:0]   d;
        bit         se;
        bit         de;
        logic [11:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int sel, input bit rst, input bit rq,
                                input bit [1:0] s, input bit [1:0] d,
                                input bit se, input bit de,
                                input logic [11:0] exp, input string name);
        vec_t v;
        v.sel = sel; v.rst = rst; v.rq = rq; v.s = s; v.d = d;
        v.se = se; v.de = de; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] got(input int sel);
        case (sel)
            0:       return {ack0, busy0, done0, err0, oe0, latch0};
            1:       return {ack1, busy1, done1, err1, oe1, latch1};
            default: return {ack2, busy2, done2, err2, 1'b0, oe2, latch2};
        endcase
    endfunction

    task automatic step(input int sel, input bit rst, input bit rq,
                        input bit [1:0] s, input bit [1:0] d,
                        input bit se, input bit de,
                        input logic [11:0] exp, input string name);
        logic [11:0] g;
        reset = rst; req = rq; src = s; dst = d; src_en = se; dst_en = de;
        @(posedge clk);
        #1;
        g = got(sel);
        n_tests++;
        if (g !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got ack/busy/done/err/oe/latch=%b_%b_%b, expected %b_%b_%b",
                     name, sel, g[11:8], g[7:4], g[3:0], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    initial begin
        logic [11:0] e;

        reset = 1'b1; req = 1'b0; src = '0; dst = '0; src_en = 1'b0; dst_en = 1'b0;

        // Reset state of every instance.
        add(0, 1, 0, 0, 0, 0, 0, 12'b0000_0000_0000, "reset0");
        add(1, 1, 0, 0, 0, 0, 0, 12'b0000_0000_0000, "reset1");
        add(2, 1, 0, 0, 0, 0, 0, 12'b0000_0000_0000, "reset2");
        // Single transfer src=2 -> dst=1.
        add(0, 0, 1, 2, 1, 1, 1, 12'b1100_0100_0000, "basic_accept");
        add(0, 0, 0, 2, 1, 1, 1, 12'b0100_0100_0010, "basic_strobe");
        add(0, 0, 0, 2, 1, 1, 1, 12'b0100_0100_0000, "basic_release");
        add(0, 0, 0, 2, 1, 1, 1, 12'b0010_0000_0000, "basic_done");
        add(0, 0, 0, 2, 1, 1, 1, 12'b0000_0000_0000, "basic_idle");
        // req held: two back-to-back transfers src=0 -> dst=3.
        add(0, 0, 1, 0, 3, 1, 1, 12'b1100_0001_0000, "b2b_ack1");
        add(0, 0, 1, 0, 3, 1, 1, 12'b0100_0001_1000, "b2b_strobe1");
        add(0, 0, 1, 0, 3, 1, 1, 12'b0100_0001_0000, "b2b_rel1");
        add(0, 0, 1, 0, 3, 1, 1, 12'b0010_0000_0000, "b2b_done1");
        add(0, 0, 1, 0, 3, 1, 1, 12'b1100_0001_0000, "b2b_ack2");
        add(0, 0, 0, 0, 3, 1, 1, 12'b0100_0001_1000, "b2b_strobe2");
        add(0, 0, 0, 0, 3, 1, 1, 12'b0100_0001_0000, "b2b_rel2");
        add(0, 0, 0, 0, 3, 1, 1, 12'b0010_0000_0000, "b2b_done2");
        add(0, 0, 0, 0, 3, 1, 1, 12'b0000_0000_0000, "b2b_idle");
        // Both enables off: full sequence, no oe/latch.
        add(0, 0, 1, 3, 2, 0, 0, 12'b1100_0000_0000, "nop_ack");
        add(0, 0, 0, 3, 2, 0, 0, 12'b0100_0000_0000, "nop_strobe");
        add(0, 0, 0, 3, 2, 0, 0, 12'b0100_0000_0000, "nop_rel");
        add(0, 0, 0, 3, 2, 0, 0, 12'b0010_0000_0000, "nop_done");
        // NSRC=3: src=3 rejected when driven, accepted when src_en=0.
        add(2, 1, 0, 0, 0, 0, 0, 12'b0000_0000_0000, "n3_reset");
        add(2, 0, 1, 3, 0, 1, 1, 12'b0001_0000_0000, "n3_err");
        add(2, 0, 0, 3, 0, 1, 1, 12'b0000_0000_0000, "n3_after_err");
        add(2, 0, 1, 3, 0, 0, 1, 12'b1100_0000_0000, "n3_accept");
        add(2, 0, 0, 3, 0, 0, 1, 12'b0100_0000_0001, "n3_strobe");
        add(2, 0, 0, 3, 0, 0, 1, 12'b0100_0000_0000, "n3_rel");
        add(2, 0, 0, 3, 0, 0, 1, 12'b0010_0000_0000, "n3_done");

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].sel, vecs[i].rst, vecs[i].rq, vecs[i].s, vecs[i].d,
                 vecs[i].se, vecs[i].de, vecs[i].exp, vecs[i].name);
        end

        // SETTLE=3, HOLD=2, src_en=0, dst=0: latch high after edges 3-4 only,
        // done after edge 6.
        step(1, 1, 0, 0, 0, 0, 0, 12'b0000_0000_0000, "sh_reset");
        for (int k = 0; k < 8; k++) begin
            e = '0;
            e[11] = (k == 0);
            e[10] = (k <= 5);
            e[9]  = (k == 6);
            e[3:0] = (k == 3 || k == 4) ? 4'b0001 : 4'b0000;
            step(1, 0, (k == 0), 1, 0, 0, 1, e, $sformatf("sh_edge%0d", k));
        end

        // Reset one cycle after latch rises: everything clears, no done,
        // and the next request runs normally.
        step(0, 1, 0, 0, 0, 0, 0, 12'b0000_0000_0000, "mid_pre_reset");
        step(0, 0, 1, 1, 2, 1, 1, 12'b1100_0010_0000, "mid_accept");
        step(0, 0, 0, 1, 2, 1, 1, 12'b0100_0010_0100, "mid_strobe");
        step(0, 1, 1, 1, 2, 1, 1, 12'b0000_0000_0000, "mid_reset");
        step(0, 0, 0, 1, 2, 1, 1, 12'b0000_0000_0000, "mid_no_done");
        step(0, 0, 1, 3, 0, 1, 1, 12'b1100_1000_0000, "post_accept");
        step(0, 0, 0, 3, 0, 1, 1, 12'b0100_1000_0001, "post_strobe");
        step(0, 0, 0, 3, 0, 1, 1, 12'b0100_1000_0000, "post_rel");
        step(0, 0, 0, 3, 0, 1, 1, 12'b0010_0000_0000, "post_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
